// File: rtl/ex_stage_pkg.sv
// Shared codes for the execute stage: bus widths, write/stall levels,
// ALU op and result-class encodings, divider states and small helpers.
package ex_stage_pkg;

  localparam int RegBusW  = 32;
  localparam int RegAddrW = 5;
  localparam int AluOpW   = 8;
  localparam int AluSelW  = 3;
  localparam int StallW   = 6;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic Stop         = 1'b1;
  localparam logic NoStop       = 1'b0;

  localparam logic [RegAddrW-1:0] NOPRegAddr = '0;
  localparam logic [RegBusW-1:0]  ZeroWord   = '0;

  localparam logic [AluOpW-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [AluOpW-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [AluOpW-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [AluOpW-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [AluOpW-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [AluOpW-1:0] EXE_LUI_OP   = 8'b0101_1100;
  localparam logic [AluOpW-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [AluOpW-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [AluOpW-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [AluOpW-1:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [AluOpW-1:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [AluOpW-1:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [AluOpW-1:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [AluOpW-1:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [AluOpW-1:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [AluOpW-1:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [AluOpW-1:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [AluOpW-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [AluOpW-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [AluOpW-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [AluOpW-1:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [AluOpW-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [AluOpW-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [AluOpW-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [AluOpW-1:0] EXE_MTLO_OP  = 8'b0001_0011;

  localparam logic [AluSelW-1:0] EXE_RES_NOP         = 3'b000;
  localparam logic [AluSelW-1:0] EXE_RES_LOGIC       = 3'b001;
  localparam logic [AluSelW-1:0] EXE_RES_SHIFT       = 3'b010;
  localparam logic [AluSelW-1:0] EXE_RES_MOVE        = 3'b011;
  localparam logic [AluSelW-1:0] EXE_RES_ARITHMETIC  = 3'b100;
  localparam logic [AluSelW-1:0] EXE_RES_MUL         = 3'b101;
  localparam logic [AluSelW-1:0] EXE_RES_JUMP_BRANCH = 3'b110;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } divState_t;

  // Magnitude of a word, treating it as two's complement only when asked.
  function automatic logic [RegBusW-1:0] absVal(input logic [RegBusW-1:0] v,
                                                input logic isSigned);
    return (isSigned && v[RegBusW-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU. One quotient bit per cycle;
// the final sign fix-up is folded into the last iteration so the result
// is ready the cycle the FSM enters DivEnd.
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [RegBusW-1:0]   opdata1,
  input  logic [RegBusW-1:0]   opdata2,
  input  logic                 ack,
  output logic [2*RegBusW-1:0] result,
  output logic                 ready
);

  localparam logic [5:0] LastIter = 6'(DIV_CYCLES - 1);

  divState_t           r_state;
  logic [5:0]          r_cnt;
  logic [RegBusW-1:0]  r_rem;
  logic [RegBusW-1:0]  r_quo;
  logic [RegBusW-1:0]  r_divisor;
  logic                r_negQuo;
  logic                r_negRem;
  logic                r_ready;
  logic [2*RegBusW-1:0] r_result;

  logic [RegBusW:0]    w_shifted;
  logic [RegBusW:0]    w_trial;
  logic                w_fits;
  logic [RegBusW-1:0]  w_nextRem;
  logic [RegBusW-1:0]  w_nextQuo;
  logic [RegBusW-1:0]  w_finalRem;
  logic [RegBusW-1:0]  w_finalQuo;

  // One restoring step: bring in the next dividend bit, try the subtract,
  // keep it only when it does not go negative.
  always_comb begin
    w_shifted  = {r_rem, r_quo[RegBusW-1]};
    w_trial    = w_shifted - {1'b0, r_divisor};
    w_fits     = ~w_trial[RegBusW];
    w_nextRem  = w_fits ? w_trial[RegBusW-1:0] : w_shifted[RegBusW-1:0];
    w_nextQuo  = {r_quo[RegBusW-2:0], w_fits};
    w_finalQuo = r_negQuo ? (~w_nextQuo + 32'd1) : w_nextQuo;
    w_finalRem = r_negRem ? (~w_nextRem + 32'd1) : w_nextRem;
  end

  // Divider FSM with its counter, datapath registers and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= DivFree;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_negQuo  <= 1'b0;
      r_negRem  <= 1'b0;
      r_ready   <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        DivFree: begin
          r_ready <= 1'b0;
          if (start) begin
            if (opdata2 == ZeroWord) begin
              r_state <= DivByZero;
            end else begin
              r_state   <= DivOn;
              r_cnt     <= '0;
              r_rem     <= '0;
              r_quo     <= absVal(opdata1, signed_div);
              r_divisor <= absVal(opdata2, signed_div);
              r_negQuo  <= signed_div & (opdata1[RegBusW-1] ^ opdata2[RegBusW-1]);
              r_negRem  <= signed_div & opdata1[RegBusW-1];
            end
          end
        end
        DivByZero: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= DivEnd;
        end
        DivOn: begin
          r_rem <= w_nextRem;
          r_quo <= w_nextQuo;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == LastIter) begin
            r_result <= {w_finalRem, w_finalQuo};
            r_ready  <= 1'b1;
            r_state  <= DivEnd;
          end
        end
        DivEnd: begin
          if (ack == NoStop) begin
            r_ready <= 1'b0;
            r_state <= DivFree;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= DivFree;
        end
      endcase
    end
  end

  assign result = r_result;
  assign ready  = r_ready;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, HI/LO write generation, the 64-bit
// multiplier and the hand-off to the multi-cycle divider with its stall.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RegAddrW-1:0] wd_i,
  input  logic                wreg_i,
  input  logic [AluOpW-1:0]   aluop_i,
  input  logic [AluSelW-1:0]  alusel_i,
  input  logic [RegBusW-1:0]  reg1_i,
  input  logic [RegBusW-1:0]  reg2_i,
  input  logic [RegBusW-1:0]  link_address_i,
  input  logic                is_in_delayslot_i,
  input  logic [RegBusW-1:0]  hi_i,
  input  logic [RegBusW-1:0]  lo_i,
  input  logic [StallW-1:0]   stall_i,
  output logic [RegAddrW-1:0] wd_o,
  output logic                wreg_o,
  output logic [RegBusW-1:0]  wdata_o,
  output logic                whilo_o,
  output logic [RegBusW-1:0]  hi_o,
  output logic [RegBusW-1:0]  lo_o,
  output logic                is_in_delayslot_o,
  output logic                stallreq_o
);

  logic [RegBusW-1:0]   w_logicOut;
  logic [RegBusW-1:0]   w_shiftOut;
  logic [RegBusW-1:0]   w_arithOut;
  logic [RegBusW-1:0]   w_moveOut;
  logic [RegBusW-1:0]   w_wdata;
  logic [2*RegBusW-1:0] w_prodSigned;
  logic [2*RegBusW-1:0] w_prodUnsigned;
  logic                 w_isDiv;
  logic                 w_isMult;
  logic                 w_hiloWe;
  logic [RegBusW-1:0]   w_hi;
  logic [RegBusW-1:0]   w_lo;
  logic [2*RegBusW-1:0] w_divResult;
  logic                 w_divReady;
  logic                 w_unusedStall;

  assign w_isDiv  = (aluop_i == EXE_DIV_OP)  || (aluop_i == EXE_DIVU_OP);
  assign w_isMult = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);

  assign w_unusedStall = ^{stall_i[5], stall_i[3:0]};

  assign w_prodSigned   = {{RegBusW{reg1_i[RegBusW-1]}}, reg1_i} *
                          {{RegBusW{reg2_i[RegBusW-1]}}, reg2_i};
  assign w_prodUnsigned = {{RegBusW{1'b0}}, reg1_i} * {{RegBusW{1'b0}}, reg2_i};

  div_unit #(.DIV_CYCLES(DIV_CYCLES)) u_divUnit (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (w_isDiv),
    .signed_div (aluop_i == EXE_DIV_OP),
    .opdata1    (reg1_i),
    .opdata2    (reg2_i),
    .ack        (stall_i[4]),
    .result     (w_divResult),
    .ready      (w_divReady)
  );

  // Bitwise logic; LUI arrives with the immediate already shifted up.
  always_comb begin
    w_logicOut = ZeroWord;
    case (aluop_i)
      EXE_AND_OP: w_logicOut = reg1_i & reg2_i;
      EXE_OR_OP,
      EXE_LUI_OP: w_logicOut = reg1_i | reg2_i;
      EXE_XOR_OP: w_logicOut = reg1_i ^ reg2_i;
      EXE_NOR_OP: w_logicOut = ~(reg1_i | reg2_i);
      default:    w_logicOut = ZeroWord;
    endcase
  end

  // Shifts move reg2 by the low five bits of reg1.
  always_comb begin
    w_shiftOut = ZeroWord;
    case (aluop_i)
      EXE_SLL_OP: w_shiftOut = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: w_shiftOut = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: w_shiftOut = $signed(reg2_i) >>> reg1_i[4:0];
      default:    w_shiftOut = ZeroWord;
    endcase
  end

  // Wrapping add/subtract and set-on-less-than; overflow is never trapped.
  always_comb begin
    w_arithOut = ZeroWord;
    case (aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP:
        w_arithOut = reg1_i + reg2_i;
      EXE_SUB_OP, EXE_SUBU_OP:
        w_arithOut = reg1_i - reg2_i;
      EXE_SLT_OP:
        w_arithOut = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP:
        w_arithOut = {31'd0, reg1_i < reg2_i};
      default:
        w_arithOut = ZeroWord;
    endcase
  end

  // HI/LO reads; the inputs are already forwarded so no local state is needed.
  always_comb begin
    w_moveOut = ZeroWord;
    case (aluop_i)
      EXE_MFHI_OP: w_moveOut = hi_i;
      EXE_MFLO_OP: w_moveOut = lo_i;
      default:     w_moveOut = ZeroWord;
    endcase
  end

  // GPR result selection by result class; link writes the return address.
  always_comb begin
    w_wdata = ZeroWord;
    case (alusel_i)
      EXE_RES_LOGIC:       w_wdata = w_logicOut;
      EXE_RES_SHIFT:       w_wdata = w_shiftOut;
      EXE_RES_MOVE:        w_wdata = w_moveOut;
      EXE_RES_ARITHMETIC:  w_wdata = w_arithOut;
      EXE_RES_JUMP_BRANCH: w_wdata = link_address_i;
      default:             w_wdata = ZeroWord;
    endcase
  end

  // HI/LO write port: moves keep the untouched half, multiply writes the
  // full product, divide writes only once the divider reports ready.
  always_comb begin
    w_hiloWe = WriteDisable;
    w_hi     = ZeroWord;
    w_lo     = ZeroWord;
    case (aluop_i)
      EXE_MTHI_OP: begin
        w_hiloWe = WriteEnable;
        w_hi     = reg1_i;
        w_lo     = lo_i;
      end
      EXE_MTLO_OP: begin
        w_hiloWe = WriteEnable;
        w_hi     = hi_i;
        w_lo     = reg1_i;
      end
      EXE_MULT_OP: begin
        w_hiloWe = WriteEnable;
        {w_hi, w_lo} = w_prodSigned;
      end
      EXE_MULTU_OP: begin
        w_hiloWe = WriteEnable;
        {w_hi, w_lo} = w_prodUnsigned;
      end
      EXE_DIV_OP, EXE_DIVU_OP: begin
        if (w_divReady) begin
          w_hiloWe = WriteEnable;
          {w_hi, w_lo} = w_divResult;
        end
      end
      default: begin
        w_hiloWe = WriteDisable;
      end
    endcase
  end

  // Everything goes quiet while reset is held; HI/LO-only ops never write a GPR.
  always_comb begin
    wd_o              = NOPRegAddr;
    wreg_o            = WriteDisable;
    wdata_o           = ZeroWord;
    whilo_o           = WriteDisable;
    hi_o              = ZeroWord;
    lo_o              = ZeroWord;
    is_in_delayslot_o = 1'b0;
    stallreq_o        = NoStop;
    if (rst_n) begin
      wd_o              = wd_i;
      wreg_o            = (w_isDiv || w_isMult) ? WriteDisable : wreg_i;
      wdata_o           = w_wdata;
      whilo_o           = w_hiloWe;
      hi_o              = w_hi;
      lo_o              = w_lo;
      is_in_delayslot_o = is_in_delayslot_i;
      stallreq_o        = (w_isDiv && !w_divReady) ? Stop : NoStop;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: single-cycle ALU ops, multiply, and the
// divider timing including divide-by-zero, held END and reset abort.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [RegAddrW-1:0] wd_i;
  logic                wreg_i;
  logic [AluOpW-1:0]   aluop_i;
  logic [AluSelW-1:0]  alusel_i;
  logic [RegBusW-1:0]  reg1_i;
  logic [RegBusW-1:0]  reg2_i;
  logic [RegBusW-1:0]  link_address_i;
  logic                is_in_delayslot_i;
  logic [RegBusW-1:0]  hi_i;
  logic [RegBusW-1:0]  lo_i;
  logic [StallW-1:0]   stall_i;
  logic [RegAddrW-1:0] wd_o;
  logic                wreg_o;
  logic [RegBusW-1:0]  wdata_o;
  logic                whilo_o;
  logic [RegBusW-1:0]  hi_o;
  logic [RegBusW-1:0]  lo_o;
  logic                is_in_delayslot_o;
  logic                stallreq_o;

  int checks;
  int failures;
  int stallCount;

  ex_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wd_i              (wd_i),
    .wreg_i            (wreg_i),
    .aluop_i           (aluop_i),
    .alusel_i          (alusel_i),
    .reg1_i            (reg1_i),
    .reg2_i            (reg2_i),
    .link_address_i    (link_address_i),
    .is_in_delayslot_i (is_in_delayslot_i),
    .hi_i              (hi_i),
    .lo_i              (lo_i),
    .stall_i           (stall_i),
    .wd_o              (wd_o),
    .wreg_o            (wreg_o),
    .wdata_o           (wdata_o),
    .whilo_o           (whilo_o),
    .hi_o              (hi_o),
    .lo_o              (lo_o),
    .is_in_delayslot_o (is_in_delayslot_o),
    .stallreq_o        (stallreq_o)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one instruction's operands.
  task automatic applyStimulus(input logic [AluOpW-1:0] op,
                               input logic [AluSelW-1:0] sel,
                               input logic [RegBusW-1:0] r1,
                               input logic [RegBusW-1:0] r2);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = r1;
    reg2_i   = r2;
  endtask

  // One comparison, counted and reported on mismatch.
  task automatic checkOutput(input string tag,
                             input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n             = 1'b0;
    wd_i              = 5'd5;
    wreg_i            = 1'b1;
    link_address_i    = 32'h0040_0008;
    is_in_delayslot_i = 1'b1;
    hi_i              = 32'h1234_5678;
    lo_i              = 32'h8765_4321;
    stall_i           = 6'b000000;
    applyStimulus(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'd1, 32'd2);

    // Reset holds every output at zero despite live inputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wdata", 64'(wdata_o), 64'h0);
    checkOutput("rst_wreg",  64'(wreg_o),  64'h0);
    checkOutput("rst_wd",    64'(wd_o),    64'h0);
    checkOutput("rst_hilo",  {hi_o, lo_o}, 64'h0);
    checkOutput("rst_misc",  64'({whilo_o, stallreq_o, is_in_delayslot_o}), 64'h0);
    rst_n = 1'b1;
    nextCycle();

    // ADDU wraps to zero.
    is_in_delayslot_i = 1'b0;
    wd_i = 5'd3;
    applyStimulus(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    checkOutput("addu_wdata", 64'(wdata_o), 64'h0);
    checkOutput("addu_wreg",  64'(wreg_o),  64'h1);
    checkOutput("addu_wd",    64'(wd_o),    64'h3);
    checkOutput("addu_stall", 64'(stallreq_o), 64'h0);

    applyStimulus(EXE_SLT_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    checkOutput("slt", 64'(wdata_o), 64'h1);
    applyStimulus(EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    checkOutput("sltu", 64'(wdata_o), 64'h0);
    applyStimulus(EXE_SUBU_OP, EXE_RES_ARITHMETIC, 32'd5, 32'd7);
    @(negedge clk);
    checkOutput("subu", 64'(wdata_o), 64'hFFFF_FFFE);

    applyStimulus(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000);
    @(negedge clk);
    checkOutput("sra", 64'(wdata_o), 64'hF800_0000);
    applyStimulus(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000);
    @(negedge clk);
    checkOutput("srl", 64'(wdata_o), 64'h0800_0000);
    applyStimulus(EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0024, 32'h0000_0003);
    @(negedge clk);
    checkOutput("sll_low5", 64'(wdata_o), 64'h0000_0030);

    applyStimulus(EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    @(negedge clk);
    checkOutput("and", 64'(wdata_o), 64'h00F0_000F);
    applyStimulus(EXE_XOR_OP, EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    @(negedge clk);
    checkOutput("xor", 64'(wdata_o), 64'hFF00_0FF0);
    applyStimulus(EXE_NOR_OP, EXE_RES_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    @(negedge clk);
    checkOutput("nor", 64'(wdata_o), 64'h000F_F000);

    applyStimulus(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("mfhi", 64'(wdata_o), 64'h1234_5678);
    applyStimulus(EXE_MTLO_OP, EXE_RES_NOP, 32'hAABB_CCDD, 32'h0);
    @(negedge clk);
    checkOutput("mtlo_we",   64'(whilo_o),  64'h1);
    checkOutput("mtlo_hilo", {hi_o, lo_o},  64'h1234_5678_AABB_CCDD);

    // Link result and delay-slot pass-through.
    is_in_delayslot_i = 1'b1;
    applyStimulus(EXE_NOP_OP, EXE_RES_JUMP_BRANCH, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("jal_wdata", 64'(wdata_o), 64'h0040_0008);
    checkOutput("jal_ds",    64'(is_in_delayslot_o), 64'h1);
    is_in_delayslot_i = 1'b0;

    // Multiply: full product to HI/LO, no GPR write.
    applyStimulus(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk);
    checkOutput("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    checkOutput("mult_we",   64'({whilo_o, wreg_o}), 64'h2);
    applyStimulus(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk);
    checkOutput("multu_hilo", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
    nextCycle();

    // DIV -7 / 2: stall for cycles 0..32, result at cycle 33.
    applyStimulus(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2);
    stallCount = 0;
    for (int c = 0; c <= 32; c++) begin
      @(negedge clk);
      if (stallreq_o === 1'b1) stallCount++;
      nextCycle();
    end
    checkOutput("div_stall_cycles", 64'(stallCount), 64'd33);
    @(negedge clk);
    checkOutput("div_end_stall", 64'(stallreq_o), 64'h0);
    checkOutput("div_end_we",    64'({whilo_o, wreg_o}), 64'h2);
    checkOutput("div_hilo",      {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    nextCycle();

    // DIVU 100 / 0 back to back: a fresh stall proves the FSM returned idle.
    applyStimulus(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd0);
    @(negedge clk);
    checkOutput("dz_c0_stall", 64'(stallreq_o), 64'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("dz_c1_stall", 64'(stallreq_o), 64'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("dz_c2_stall", 64'(stallreq_o), 64'h0);
    checkOutput("dz_c2_we",    64'(whilo_o), 64'h1);
    checkOutput("dz_c2_hilo",  {hi_o, lo_o}, 64'h0);
    nextCycle();

    // DIVU 100 / 7 with END held by stall_i[4] for three cycles.
    stall_i = 6'b011111;
    applyStimulus(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
    stallCount = 0;
    for (int c = 0; c <= 32; c++) begin
      @(negedge clk);
      if (stallreq_o === 1'b1) stallCount++;
      nextCycle();
    end
    checkOutput("hold_stall_cycles", 64'(stallCount), 64'd33);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("hold_stall", 64'(stallreq_o), 64'h0);
      checkOutput("hold_hilo",  {hi_o, lo_o, 1'b0} >> 1, 64'h0000_0002_0000_000E);
      checkOutput("hold_we",    64'(whilo_o), 64'h1);
      if (k == 2) stall_i = 6'b000000;
      nextCycle();
    end
    applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("hold_release_state", 64'(dut.u_divUnit.r_state), 64'(DivFree));
    checkOutput("hold_release_out",   64'({whilo_o, stallreq_o}), 64'h0);
    nextCycle();

    // Reset at cycle 10 of a divide aborts it with nothing written.
    applyStimulus(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7);
    for (int c = 0; c < 10; c++) nextCycle();
    @(negedge clk);
    checkOutput("abort_pre_stall", 64'(stallreq_o), 64'h1);
    nextCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_state", 64'(dut.u_divUnit.r_state), 64'(DivFree));
    checkOutput("abort_out",   64'({whilo_o, stallreq_o, wreg_o}), 64'h0);
    checkOutput("abort_hilo",  {hi_o, lo_o}, 64'h0);
    @(negedge clk);
    applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
    rst_n = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("abort_after_state", 64'(dut.u_divUnit.r_state), 64'(DivFree));
    checkOutput("abort_after_out",   64'({whilo_o, stallreq_o}), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
